// File: rtl/bcd_updown_counter_pkg.sv
// Shared BCD definitions: digit width, digit limits and small digit helpers
// used by the up/down counter and its per-digit slice.
`timescale 1ns/1ps
package bcd_updown_counter_pkg;

   // One BCD digit occupies a nibble; legal values are 0..9.
   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   typedef logic [BCD_W-1:0] bcd_nib_t;

   // True when the nibble is a legal decimal digit.
   function automatic logic bcd_valid(input bcd_nib_t n);
      return (n <= BCD_MAX);
   endfunction

   // Illegal nibbles (10..15) collapse to 0 so a bad load can never
   // leave a non-decimal value on the count.
   function automatic bcd_nib_t bcd_sanitize(input bcd_nib_t n);
      return bcd_valid(n) ? n : BCD_MIN;
   endfunction

   // Next digit counting up; 9 rolls to 0 (the carry is handled by the chain).
   function automatic bcd_nib_t bcd_inc(input bcd_nib_t n);
      return (n >= BCD_MAX) ? BCD_MIN : (n + 4'd1);
   endfunction

   // Next digit counting down; 0 rolls to 9 (the borrow is handled by the chain).
   // An out-of-range value also lands on 9 so the digit re-enters the legal range.
   function automatic bcd_nib_t bcd_dec(input bcd_nib_t n);
      return ((n == BCD_MIN) || !bcd_valid(n)) ? BCD_MAX : (n - 4'd1);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the counter: holds its own registered nibble,
// accepts a parallel load and steps up or down when its carry-in is set.
// Carry-out is purely combinational so the whole chain ripples within a cycle.
`timescale 1ns/1ps
module bcd_digit
   import bcd_updown_counter_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     load_i,
   input  bcd_nib_t load_nib_i,
   input  logic     up_i,
   input  logic     cin_i,
   output bcd_nib_t digit_o,
   output logic     cout_o,
   output logic     at_max_o,
   output logic     at_min_o
);

   bcd_nib_t digit_q;
   bcd_nib_t digit_d;

   // Limit flags feed both the carry chain and the terminal-count decode.
   assign at_max_o = (digit_q == BCD_MAX);
   assign at_min_o = (digit_q == BCD_MIN);

   // Ripple to the next digit only when this one rolls over in the current direction.
   assign cout_o   = cin_i & (up_i ? at_max_o : at_min_o);

   assign digit_o  = digit_q;

   // Next digit value: load wins over stepping; no carry-in means hold.
   always_comb begin
      digit_d = digit_q;
      if (load_i) begin
         digit_d = bcd_sanitize(load_nib_i);
      end else if (cin_i) begin
         digit_d = up_i ? bcd_inc(digit_q) : bcd_dec(digit_q);
      end
   end

   // Digit register, cleared asynchronously.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         digit_q <= BCD_MIN;
      end else begin
         digit_q <= digit_d;
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, wrap or saturate
// behaviour at the limits, a combinational terminal-count flag and
// registered one-cycle pulses for limit hits and illegal load digits.
`timescale 1ns/1ps
module bcd_updown_counter
   import bcd_updown_counter_pkg::*;
#(
   parameter int DIGITS = 4,   // number of BCD digits, 1..8
   parameter int WRAP   = 1    // 1 = wrap at the limits, 0 = saturate
) (
   input  logic                  p_clk_in,
   input  logic                  p_rst,
   input  logic                  en,
   input  logic                  up_dn,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  tc,
   output logic                  ovf,
   output logic                  load_err
);

   localparam logic SATURATE = (WRAP == 0) ? 1'b1 : 1'b0;

   // carry[k] is the step request into digit k; carry[DIGITS] leaves the top digit.
   logic [DIGITS:0]   carry;
   logic [DIGITS-1:0] at_max;
   logic [DIGITS-1:0] at_min;
   logic [DIGITS-1:0] nib_bad;

   logic all_max;
   logic all_min;
   logic at_limit;
   logic step_en;
   logic sat_hit;

   logic ovf_q;
   logic ovf_d;
   logic load_err_q;
   logic load_err_d;

   assign all_max  = &at_max;
   assign all_min  = &at_min;

   // Terminal count looks at the direction currently requested, not at en.
   assign at_limit = up_dn ? all_max : all_min;
   assign tc       = at_limit;

   // In saturate mode a step past the limit is suppressed entirely, so the
   // count holds; in wrap mode the step ripples through every digit and rolls.
   assign step_en  = en & ~load & ~(SATURATE & at_limit);
   assign carry[0] = step_en;

   // Attempted step at the limit while saturating.
   assign sat_hit  = en & ~load & at_limit & SATURATE;

   // Digit slices and the combinational carry chain between them.
   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit u_digit (
         .clk_i      (p_clk_in),
         .rst_i      (p_rst),
         .load_i     (load),
         .load_nib_i (load_val[k*BCD_W +: BCD_W]),
         .up_i       (up_dn),
         .cin_i      (carry[k]),
         .digit_o    (count[k*BCD_W +: BCD_W]),
         .cout_o     (carry[k+1]),
         .at_max_o   (at_max[k]),
         .at_min_o   (at_min[k])
      );

      assign nib_bad[k] = ~bcd_valid(load_val[k*BCD_W +: BCD_W]);
   end

   // Pulse sources: a wrap shows up as a carry out of the top digit, a
   // saturated attempt as sat_hit; a load with any illegal nibble flags load_err.
   always_comb begin
      ovf_d      = carry[DIGITS] | sat_hit;
      load_err_d = load & (|nib_bad);
   end

   // Registered one-cycle status pulses, cleared asynchronously.
   always_ff @(posedge p_clk_in or posedge p_rst) begin
      if (p_rst) begin
         ovf_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         ovf_q      <= ovf_d;
         load_err_q <= load_err_d;
      end
   end

   assign ovf      = ovf_q;
   assign load_err = load_err_q;

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits (legal 1..8).
REQ-002 SHALL have parameter WRAP, default 1, 1 = wrap at limits, 0 = saturate at limits.
REQ-003 SHALL have port p_clk_in  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port p_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up_dn  input  1  direction, 1 = up, 0 = down.
REQ-007 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 SHALL have port load_val  input  4*DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-009 SHALL have port count  output  4*DIGITS  registered BCD count, digit 0 least significant.
REQ-010 SHALL have port tc  output  1  combinational terminal count for current direction.
REQ-011 SHALL have port ovf  output  1  registered one-cycle limit-crossing/limit-hit pulse.
REQ-012 SHALL have port load_err  output  1  registered one-cycle pulse on an invalid load digit.

Function
REQ-013 SHALL apply priority on each edge: load > en > hold.
REQ-014 SHALL, on load, set each digit to its load_val nibble if <= 9, else to 0, regardless of en.
REQ-015 SHALL pulse load_err the cycle after a load containing any nibble > 9; 0 otherwise.
REQ-016 SHALL, with en=1 and load=0, change count by exactly 1 decimal step per clock in the up_dn direction.
REQ-017 SHALL propagate carries: digit k increments only when all lower digits are 9 (up) and decrements only when all lower digits are 0 (down).
REQ-018 SHALL keep every digit in 0..9 at all times; no binary value 10..15 ever appears on count.
REQ-019 SHALL drive tc=1 when (up_dn=1 and count = all 9s) or (up_dn=0 and count = all 0s), independent of en.
REQ-020 SHALL, WRAP=1: up from all 9s -> all 0s, down from all 0s -> all 9s, with ovf=1 the following cycle.
REQ-021 SHALL, WRAP=0: count holds at the limit when stepped past it, with ovf=1 for each such attempted step.
REQ-022 SHALL keep ovf=0 on load cycles, hold cycles and non-limit steps.
REQ-023 SHALL take up_dn changes effect on the next enabled edge, with no extra latency.

Reset
REQ-024 SHALL, while p_rst=1, force count=0, ovf=0 and load_err=0 immediately, independent of p_clk_in.
REQ-025 SHALL let reset asserted mid-count or coincident with load override both; the first edge after deassertion acts normally.

Structure
REQ-026 SHALL define the BCD constants (digit width 4, max digit 9) in a shared include file used by this block and dec_counter.
REQ-027 SHALL instantiate DIGITS copies of the sub-module bcd_digit (one digit: count, load, carry-in/out, up/down) via generate.
REQ-028 SHALL compute the carry chain combinationally between bcd_digit instances; only count, ovf and load_err are registered.

Verification (DIGITS=4 unless stated)
REQ-029 SHALL check reset: p_rst pulsed between edges mid-count at 0x0375 -> count=0x0000 before the next edge, ovf=0.
REQ-030 SHALL check up carry: load 0x0199, en=1, up_dn=1, 2 edges -> 0x0200 then 0x0201; tc=0 throughout.
REQ-031 SHALL check wrap up, WRAP=1: load 0x9998, up, 3 edges -> 0x9999 (tc=1), 0x0000 with ovf=1, 0x0001 with ovf=0.
REQ-032 SHALL check saturate down, WRAP=0: load 0x0001, down, 3 edges -> 0x0000, 0x0000, 0x0000; ovf=1 on the 2nd and 3rd cycles; tc=1.
REQ-033 SHALL check invalid load: load 0x12F4 with en=1 -> count=0x1204, load_err=1 for one cycle, no step applied.
REQ-034 SHALL check DIGITS=1: en=1, up, from 0 for 12 edges -> 1..9,0,1,2 with ovf=1 only after 9->0.
